emb_lut_loader: RTL

EMB_LUT_LOADER -- requirements
Module: emb_lut_loader

---
 rtl/emb_pkg.sv | 12 +
 rtl/sram_v2.sv | 29 ++
 rtl/emb_lut_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/emb_pkg.sv
// Shared sizing and FSM encodings for the embedded LUT loader and its lookup-side wrapper.
package emb_pkg;
   localparam int EMB_ADDR_W = 11;
   localparam int EMB_DATA_W = 32;
   localparam int EMB_DEPTH  = 1 << EMB_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;
endpackage

// File: rtl/sram_v2.sv
// Single-port synchronous SRAM model: active-low chip/write enables, registered read data.
module sram_v2 #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048
) (
   input  logic              clk,
   input  logic              ceb,
   input  logic              web,
   input  logic [DATA_W-1:0] datai,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] datao
);
   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DATA_W-1:0] datao_reg;

   // No reset here: the table contents must survive a loader reset.
   always_ff @(posedge clk) begin
      if (!ceb) begin
         if (!web) begin
            mem_reg[addr] <= datai;
         end else begin
            datao_reg <= mem_reg[addr];
         end
      end
   end

   assign datao = datao_reg;
endmodule

// File: rtl/emb_lut_loader.sv
// Streams a block of words into the LUT SRAM at a given base address and serves
// single-cycle-latency lookups whenever no load is running.
module emb_lut_loader
   import emb_pkg::*;
#(
   parameter int ADDR_W = EMB_ADDR_W,
   parameter int DATA_W = EMB_DATA_W,
   parameter int DEPTH  = EMB_DEPTH
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W:0]   rem_reg, rem_next;
   logic              err_reg, err_next;
   logic              rd_valid_reg, rd_valid_next;
   logic              len_ok;
   logic              wr_fire;
   logic              rd_fire;

   logic              sram_ceb;
   logic              sram_web;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_datai;
   logic [DATA_W-1:0] sram_datao;

   assign len_ok = (len != '0) && (len <= DEPTH_L);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         rem_reg      <= '0;
         err_reg      <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         rem_reg      <= rem_next;
         err_reg      <= err_next;
         rd_valid_reg <= rd_valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      rem_next      = rem_reg;
      err_next      = 1'b0;
      rd_valid_next = 1'b0;
      wr_fire       = 1'b0;
      rd_fire       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // A read coinciding with an accepted start is dropped so no read
            // result can surface inside the busy window.
            rd_fire       = rd_en && !(start && len_ok);
            rd_valid_next = rd_fire;
            if (start) begin
               if (len_ok) begin
                  state_next = ST_LOAD;
                  addr_next  = start_addr;
                  rem_next   = len;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            wr_fire = wr_valid;
            if (wr_valid) begin
               addr_next = addr_reg + 1'b1;
               rem_next  = rem_reg - ONE_L;
               if (rem_reg == ONE_L) begin
                  state_next = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign wr_ready = (state_reg == ST_LOAD);
   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_FLUSH);
   assign err      = err_reg;
   assign rd_valid = rd_valid_reg;
   assign rd_data  = sram_datao;

   // Single address mux: the write path wins whenever a word is accepted.
   assign sram_ceb   = !(wr_fire || rd_fire);
   assign sram_web   = !wr_fire;
   assign sram_addr  = wr_fire ? addr_reg : rd_addr;
   assign sram_datai = wr_data;

   sram_v2 #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_sram (
      .clk   (clk),
      .ceb   (sram_ceb),
      .web   (sram_web),
      .datai (sram_datai),
      .addr  (sram_addr),
      .datao (sram_datao)
   );
endmodule
